lz77_code_fifo: RTL and testbench

LZ77_CODE_FIFO -- requirements
Module: lz77_code_fifo

---
 rtl/lz77_pkg.sv | 18 +
 rtl/lz77_code_ram.sv | 26 ++
 rtl/lz77_code_fifo.sv | 122 ++++++++++++
 tb/tb_lz77_code_fifo.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lz77_pkg.sv
// Shared LZ77 code definitions for the encoder/decoder code path.
// Field widths and the packed code entry layout.
package lz77_pkg;

  localparam int OFFSET_W   = 4;
  localparam int LEN_W      = 3;
  localparam int CHAR_W     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int CODE_W     = OFFSET_W + LEN_W + CHAR_W + 1;

  typedef struct packed {
    logic [OFFSET_W-1:0] offset;
    logic [LEN_W-1:0]    match_len;
    logic [CHAR_W-1:0]   char_nxt;
    logic                last;
  } lz77_code_t;

endpackage

// File: rtl/lz77_code_ram.sv
// Code storage: register file with synchronous write, asynchronous read.
// Deliberately not reset; the FIFO never exposes entries while empty.
module lz77_code_ram #(
  parameter int DEPTH = 8,
  parameter int CW    = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [CW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [CW-1:0] rdata
);

  logic [CW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lz77_code_fifo.sv
// Show-ahead FIFO carrying LZ77 codes from encoder to decoder,
// with sticky overflow and end-of-string (done) tracking.
module lz77_code_fifo
  import lz77_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CW    = CODE_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [OFFSET_W-1:0]       in_offset,
  input  logic [LEN_W-1:0]          in_match_len,
  input  logic [CHAR_W-1:0]         in_char_nxt,
  input  logic                      in_finish,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OFFSET_W-1:0]       out_offset,
  output logic [LEN_W-1:0]          out_match_len,
  output logic [CHAR_W-1:0]         out_char_nxt,
  output logic                      out_last,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      done
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;

  logic          push;
  logic          pop;
  lz77_code_t    wr_code;
  lz77_code_t    head;
  logic [CW-1:0] rdata;

  assign out_valid = (count_q != '0);
  assign busy      = (count_q == (AW+1)'(DEPTH));

  assign push = in_valid & ~busy & ~done_q;
  assign pop  = out_valid & out_ready;

  assign wr_code = '{
    offset:    in_offset,
    match_len: in_match_len,
    char_nxt:  in_char_nxt,
    last:      in_finish
  };

  lz77_code_ram #(
    .DEPTH(DEPTH),
    .CW   (CW),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata(wr_code),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );

  assign head = rdata;

  // Fields are forced to zero so stale storage never leaks when empty.
  assign out_offset    = out_valid ? head.offset    : '0;
  assign out_match_len = out_valid ? head.match_len : '0;
  assign out_char_nxt  = out_valid ? head.char_nxt  : '0;
  assign out_last      = out_valid ? head.last      : 1'b0;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = done_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Codes arriving after the string finished are ignored, not overflow.
    if (in_valid & busy & ~done_q) begin
      overflow_d = 1'b1;
    end
    if (pop & head.last) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lz77_code_fifo.sv
// Scoreboard bench for lz77_code_fifo: queue-based reference model,
// directed scenarios plus randomized traffic.
module tb_lz77_code_fifo;
  import lz77_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_offset = '0;
  logic [2:0] in_match_len = '0;
  logic [7:0] in_char_nxt = '0;
  logic       in_finish = 1'b0;
  logic       out_ready = 1'b0;
  logic       busy, out_valid, out_last, overflow, done;
  logic [3:0] out_offset;
  logic [2:0] out_match_len;
  logic [7:0] out_char_nxt;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  lz77_code_t mq[$];
  lz77_code_t sbq[$];
  bit ovf_m = 0;
  bit done_m = 0;

  lz77_code_fifo #(.DEPTH(DEPTH), .CW(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_offset    (in_offset),
    .in_match_len (in_match_len),
    .in_char_nxt  (in_char_nxt),
    .in_finish    (in_finish),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_offset   (out_offset),
    .out_match_len(out_match_len),
    .out_char_nxt (out_char_nxt),
    .out_last     (out_last),
    .count        (count),
    .overflow     (overflow),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: every handshake must deliver the oldest accepted code.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      lz77_code_t got, exp;
      got = '{out_offset, out_match_len, out_char_nxt, out_last};
      if (sbq.size() == 0) begin
        chk("pop_unexpected", int'(got), -1);
      end else begin
        exp = sbq.pop_front();
        chk("pop_code", int'(got), int'(exp));
      end
    end
  end

  task automatic check_state(string tag);
    lz77_code_t h;
    chk({tag, ":count"}, int'(count), mq.size());
    chk({tag, ":out_valid"}, int'(out_valid), int'(mq.size() != 0));
    chk({tag, ":busy"}, int'(busy), int'(mq.size() == DEPTH));
    chk({tag, ":overflow"}, int'(overflow), int'(ovf_m));
    chk({tag, ":done"}, int'(done), int'(done_m));
    h = '{out_offset, out_match_len, out_char_nxt, out_last};
    if (mq.size() == 0) chk({tag, ":zero_fields"}, int'(h), 0);
    else chk({tag, ":head"}, int'(h), int'(mq[0]));
  endtask

  task automatic cycle(string tag, bit v, logic [3:0] off,
                       logic [2:0] len, logic [7:0] ch,
                       bit fin, bit rdy);
    bit full, push_ok, pop_ok;
    lz77_code_t c, p;
    in_valid = v;
    in_offset = off;
    in_match_len = len;
    in_char_nxt = ch;
    in_finish = fin;
    out_ready = rdy;
    c = '{off, len, ch, fin};
    full = (mq.size() == DEPTH);
    push_ok = v && !full && !done_m;
    pop_ok = (mq.size() > 0) && rdy;
    @(posedge clk);
    if (v && full && !done_m) ovf_m = 1;
    if (pop_ok) begin
      p = mq.pop_front();
      if (p.last) done_m = 1;
    end
    if (push_ok) begin
      mq.push_back(c);
      sbq.push_back(c);
    end
    #1;
    check_state(tag);
  endtask

  task automatic idle(string tag, bit rdy);
    cycle(tag, 0, 4'd0, 3'd0, 8'd0, 0, rdy);
  endtask

  task automatic do_reset(string tag);
    #2;
    reset = 1'b1;
    in_valid = 1'b0;
    in_finish = 1'b0;
    out_ready = 1'b0;
    #1;
    mq.delete();
    sbq.delete();
    ovf_m = 0;
    done_m = 0;
    check_state(tag);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    do_reset("reset0");

    cycle("push_A", 1, 4'd3, 3'd2, 8'h41, 0, 0);
    cycle("push_B", 1, 4'd0, 3'd0, 8'h42, 0, 0);
    chk("head_offset", int'(out_offset), 3);
    chk("head_len", int'(out_match_len), 2);
    chk("head_char", int'(out_char_nxt), 8'h41);
    idle("pop_1", 1);
    idle("pop_2", 1);
    chk("drained", int'(count), 0);

    for (int i = 0; i < DEPTH; i++)
      cycle("fill", 1, 4'(i), 3'(i), 8'(8'h60 + i), 0, 0);
    chk("full_busy", int'(busy), 1);
    cycle("drop9", 1, 4'hF, 3'd7, 8'hFF, 0, 0);
    chk("ovf_set", int'(overflow), 1);
    cycle("full_pp", 1, 4'hE, 3'd6, 8'hEE, 0, 1);
    chk("full_pp_cnt", int'(count), 7);
    repeat (8) idle("drain", 1);
    chk("ovf_sticky", int'(overflow), 1);

    do_reset("reset1");
    cycle("steady0", 1, 4'd1, 3'd1, 8'h30, 0, 0);
    for (int i = 0; i < 20; i++)
      cycle("steady", 1, 4'(i), 3'(i + 1), 8'(8'h31 + i), 0, 1);
    idle("steady_end", 1);
    chk("steady_ovf", int'(overflow), 0);

    do_reset("reset2");
    cycle("push_Z", 1, 4'd1, 3'd1, 8'h5A, 1, 0);
    chk("last_shown", int'(out_last), 1);
    cycle("fin_nv", 0, 4'd0, 3'd0, 8'h00, 1, 1);
    chk("done_set", int'(done), 1);
    cycle("post_done", 1, 4'd2, 3'd2, 8'h11, 0, 0);
    chk("post_done_cnt", int'(count), 0);

    do_reset("reset3");
    cycle("finish_nv", 0, 4'd5, 3'd5, 8'h55, 1, 0);
    for (int i = 0; i < 5; i++)
      cycle("five", 1, 4'(i), 3'(i), 8'(i), 0, 0);
    chk("five_cnt", int'(count), 5);
    do_reset("async_rst");

    for (int b = 0; b < 4; b++) begin
      int pv, pr;
      pv = (b % 2 == 0) ? 3 : 1;
      pr = (b < 2) ? 1 : 3;
      do_reset("rnd_rst");
      repeat (150) begin
        bit v, r, f;
        v = ($urandom_range(0, 3) < pv);
        r = ($urandom_range(0, 3) < pr);
        f = ($urandom_range(0, 59) == 0);
        cycle("rnd", v, 4'($urandom), 3'($urandom),
              8'($urandom), f, r);
      end
    end

    idle("final", 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
